// File: rtl/tinyrisc_pkg.sv
// Shared TinyRISC definitions used by the forwarding unit:
// - opcodes
// - instruction field positions
// - forwarding select encodings
// - the per-stage decode record
package tinyrisc_pkg;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_MOD  = 5'b00100;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_LSL  = 5'b01010;
    localparam logic [4:0] OP_LSR  = 5'b01011;
    localparam logic [4:0] OP_ASR  = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;

    // Field bit positions
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned IMM_BIT = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS1_MSB = 21;
    localparam int unsigned RS1_LSB = 18;
    localparam int unsigned RS2_MSB = 17;
    localparam int unsigned RS2_LSB = 14;

    // Return-address register written by call and read by ret
    localparam logic [3:0] RA_REG = 4'd15;

    // Forwarding select encodings for the EX operand muxes
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MA   = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    // Register usage of one instruction
    typedef struct packed {
        logic       is_writer;
        logic [3:0] dest;
        logic       reads_s1;
        logic [3:0] s1;
        logic       reads_s2;
        logic [3:0] s2;
    } fu_dec_t;

endpackage

// File: rtl/fu_decode.sv
// Register-usage decoder for one pipeline stage.
// Reports whether the instruction writes a destination and which sources it reads.
// When FU_RA_FWD_EN is defined:
// - call writes r15
// - ret reads r15 as source-1
module fu_decode
    import tinyrisc_pkg::*;
(
    input  logic [31:0] instr_i,
    output fu_dec_t     dec_o
);

    logic [4:0] opcode;
    logic       imm;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       unused_instr;

    assign opcode       = instr_i[OPC_MSB:OPC_LSB];
    assign imm          = instr_i[IMM_BIT];
    assign rd           = instr_i[RD_MSB:RD_LSB];
    assign rs1          = instr_i[RS1_MSB:RS1_LSB];
    assign rs2          = instr_i[RS2_MSB:RS2_LSB];
    assign unused_instr = ^instr_i[RS2_LSB-1:0];

    // Classify the opcode into writer / source-1 / source-2 usage
    always_comb begin
        dec_o = '0;
        dec_o.dest = rd;
        dec_o.s1   = rs1;
        dec_o.s2   = rs2;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
            OP_AND, OP_OR, OP_LSL, OP_LSR, OP_ASR: begin
                dec_o.is_writer = 1'b1;
                dec_o.reads_s1  = 1'b1;
                dec_o.reads_s2  = ~imm;
            end
            OP_CMP: begin
                dec_o.reads_s1 = 1'b1;
                dec_o.reads_s2 = ~imm;
            end
            OP_NOT, OP_MOV: begin
                dec_o.is_writer = 1'b1;
                dec_o.reads_s2  = ~imm;
            end
            OP_LD: begin
                dec_o.is_writer = 1'b1;
                dec_o.reads_s1  = 1'b1;
            end
            OP_ST: begin
                // Store data comes from the rd field
                dec_o.reads_s1 = 1'b1;
                dec_o.reads_s2 = 1'b1;
                dec_o.s2       = rd;
            end
`ifdef FU_RA_FWD_EN
            OP_CALL: begin
                dec_o.is_writer = 1'b1;
                dec_o.dest      = RA_REG;
            end
            OP_RET: begin
                dec_o.reads_s1 = 1'b1;
                dec_o.s1       = RA_REG;
            end
`endif
            default: begin
                // nop, branches and undefined opcodes touch no registers
            end
        endcase
    end

endmodule

// File: rtl/forwarding_unit.sv
// Data-forwarding control for the 5-stage TinyRISC pipeline.
// - The OF, EX, MA and WB instructions are decoded.
// - Purely combinational mux selects route MA/WB results to earlier operands.
// - A saturating counter tracks cycles in which any forwarding occurs.
// Optional macro FU_RA_FWD_EN lets call/ret take part through r15.
module forwarding_unit
    import tinyrisc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instruction_OF,
    input  logic [31:0]      instruction_EX,
    input  logic [31:0]      instruction_MA,
    input  logic [31:0]      instruction_WB,
    output logic             WB_OF_rs1,
    output logic             WB_OF_rs2,
    output logic             WB_MA_rs2,
    output logic [1:0]       MAWB_EX_rs1,
    output logic [1:0]       MAWB_EX_rs2,
    output logic [CNT_W-1:0] fwd_count
);

    fu_dec_t dec_of;
    fu_dec_t dec_ex;
    fu_dec_t dec_ma;
    fu_dec_t dec_wb;

    logic              ma_is_ld;
    logic              ma_is_st;
    logic              any_fwd;
    logic [CNT_W-1:0]  fwd_count_d;
    logic [CNT_W-1:0]  fwd_count_q;
    logic              unused_dec;

    fu_decode u_dec_of (.instr_i(instruction_OF), .dec_o(dec_of));
    fu_decode u_dec_ex (.instr_i(instruction_EX), .dec_o(dec_ex));
    fu_decode u_dec_ma (.instr_i(instruction_MA), .dec_o(dec_ma));
    fu_decode u_dec_wb (.instr_i(instruction_WB), .dec_o(dec_wb));

    assign ma_is_ld = (instruction_MA[OPC_MSB:OPC_LSB] == OP_LD);
    assign ma_is_st = (instruction_MA[OPC_MSB:OPC_LSB] == OP_ST);

    // Decode fields that no forwarding path consumes
    assign unused_dec = ^{dec_of.is_writer, dec_of.dest, dec_ex.is_writer, dec_ex.dest,
                          dec_ma.reads_s1, dec_ma.s1, dec_wb.reads_s1, dec_wb.s1,
                          dec_wb.reads_s2, dec_wb.s2};

    // WB result forwarded into OF operands and into MA store data
    always_comb begin
        WB_OF_rs1 = dec_wb.is_writer && dec_of.reads_s1 && (dec_wb.dest == dec_of.s1);
        WB_OF_rs2 = dec_wb.is_writer && dec_of.reads_s2 && (dec_wb.dest == dec_of.s2);
        // For a store, decode reports the rd field as source-2
        WB_MA_rs2 = ma_is_st && dec_ma.reads_s2 && dec_wb.is_writer &&
                    (dec_wb.dest == dec_ma.s2);
    end

    // EX operand selects; MA beats WB, and a load in MA is left to the stall unit
    always_comb begin
        MAWB_EX_rs1 = FWD_NONE;
        MAWB_EX_rs2 = FWD_NONE;
        if (dec_ex.reads_s1) begin
            if (dec_ma.is_writer && !ma_is_ld && (dec_ma.dest == dec_ex.s1)) begin
                MAWB_EX_rs1 = FWD_MA;
            end else if (dec_wb.is_writer && (dec_wb.dest == dec_ex.s1)) begin
                MAWB_EX_rs1 = FWD_WB;
            end
        end
        if (dec_ex.reads_s2) begin
            if (dec_ma.is_writer && !ma_is_ld && (dec_ma.dest == dec_ex.s2)) begin
                MAWB_EX_rs2 = FWD_MA;
            end else if (dec_wb.is_writer && (dec_wb.dest == dec_ex.s2)) begin
                MAWB_EX_rs2 = FWD_WB;
            end
        end
    end

    // Next value of the saturating forwarding-activity counter
    always_comb begin
        any_fwd = WB_OF_rs1 || WB_OF_rs2 || WB_MA_rs2 ||
                  (MAWB_EX_rs1 != FWD_NONE) || (MAWB_EX_rs2 != FWD_NONE);
        fwd_count_d = fwd_count_q;
        if (any_fwd && !(&fwd_count_q)) begin
            fwd_count_d = fwd_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_count_q <= '0;
        end else begin
            fwd_count_q <= fwd_count_d;
        end
    end

    assign fwd_count = fwd_count_q;

endmodule

// File: tb/tb_forwarding_unit.sv
// Self-checking bench for forwarding_unit.
// - Directed steps mirror the intended use cases.
// - Random instruction mixes are compared against a table-driven register-usage model.
// - A 4-bit counter instance exercises saturation quickly.
module tb_forwarding_unit;

    localparam logic [4:0] NOP = 5'd13;

    logic        clk;
    logic        rst_n;
    logic [31:0] of_in, ex_in, ma_in, wb_in;
    logic        wb_of1, wb_of2, wb_ma2;
    logic [1:0]  ex1, ex2;
    logic [15:0] cnt;
    logic        s_wb_of1, s_wb_of2, s_wb_ma2;
    logic [1:0]  s_ex1, s_ex2;
    logic [3:0]  s_cnt;

    int checks = 0;
    int fails  = 0;

    // Model state
    bit [31:0] writer_m, src1_m, src2r_m;
    int        cnt_model;
    int        scnt_model;

    typedef struct {
        bit       w;
        bit [3:0] d;
        bit       r1;
        bit [3:0] a1;
        bit       r2;
        bit [3:0] a2;
        bit [4:0] op;
    } mdec_t;

    forwarding_unit dut (
        .clk(clk), .rst_n(rst_n),
        .instruction_OF(of_in), .instruction_EX(ex_in),
        .instruction_MA(ma_in), .instruction_WB(wb_in),
        .WB_OF_rs1(wb_of1), .WB_OF_rs2(wb_of2), .WB_MA_rs2(wb_ma2),
        .MAWB_EX_rs1(ex1), .MAWB_EX_rs2(ex2), .fwd_count(cnt)
    );

    forwarding_unit #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .instruction_OF(of_in), .instruction_EX(ex_in),
        .instruction_MA(ma_in), .instruction_WB(wb_in),
        .WB_OF_rs1(s_wb_of1), .WB_OF_rs2(s_wb_of2), .WB_MA_rs2(s_wb_ma2),
        .MAWB_EX_rs1(s_ex1), .MAWB_EX_rs2(s_ex2), .fwd_count(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic i, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, i, rd, rs1, rs2, 14'd0};
    endfunction

    function automatic mdec_t mdec(input logic [31:0] ins);
        mdec_t x;
        x.op = ins[31:27];
        x.w  = writer_m[x.op];
        x.d  = ins[25:22];
        x.r1 = src1_m[x.op];
        x.a1 = ins[21:18];
        x.r2 = src2r_m[x.op] && !ins[26];
        x.a2 = ins[17:14];
        if (x.op == 5'd15) begin
            x.r2 = 1'b1;
            x.a2 = ins[25:22];
        end
`ifdef FU_RA_FWD_EN
        if (x.op == 5'd19) x.d = 4'd15;
        if (x.op == 5'd20) x.a1 = 4'd15;
`endif
        return x;
    endfunction

    function automatic logic [1:0] exsel(input bit r, input bit [3:0] a, input mdec_t m,
                                         input mdec_t w);
        if (!r) return 2'd0;
        if (m.w && m.op != 5'd14 && m.d == a) return 2'd1;
        if (w.w && w.d == a) return 2'd2;
        return 2'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stage contents, check selects, then the counters after the edge
    task automatic step(input logic [31:0] o, input logic [31:0] e, input logic [31:0] m,
                        input logic [31:0] w);
        mdec_t dO, dE, dM, dW;
        bit    e_of1, e_of2, e_ma2, any;
        logic [1:0] e_ex1, e_ex2;
        @(negedge clk);
        of_in = o; ex_in = e; ma_in = m; wb_in = w;
        #1;
        dO = mdec(o); dE = mdec(e); dM = mdec(m); dW = mdec(w);
        e_of1 = dW.w && dO.r1 && dW.d == dO.a1;
        e_of2 = dW.w && dO.r2 && dW.d == dO.a2;
        e_ma2 = dM.op == 5'd15 && dW.w && dW.d == m[25:22];
        e_ex1 = exsel(dE.r1, dE.a1, dM, dW);
        e_ex2 = exsel(dE.r2, dE.a2, dM, dW);
        check("WB_OF_rs1", {31'd0, wb_of1}, {31'd0, e_of1});
        check("WB_OF_rs2", {31'd0, wb_of2}, {31'd0, e_of2});
        check("WB_MA_rs2", {31'd0, wb_ma2}, {31'd0, e_ma2});
        check("MAWB_EX_rs1", {30'd0, ex1}, {30'd0, e_ex1});
        check("MAWB_EX_rs2", {30'd0, ex2}, {30'd0, e_ex2});
        any = e_of1 || e_of2 || e_ma2 || e_ex1 != 0 || e_ex2 != 0;
        @(posedge clk);
        #1;
        if (any && cnt_model < 65535) cnt_model++;
        if (any && scnt_model < 15) scnt_model++;
        check("fwd_count", {16'd0, cnt}, cnt_model);
        check("fwd_count_small", {28'd0, s_cnt}, scnt_model);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        cnt_model  = 0;
        scnt_model = 0;
        check("reset_count", {16'd0, cnt}, 0);
        check("reset_count_small", {28'd0, s_cnt}, 0);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_instr();
        return enc(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)));
    endfunction

    initial begin
        logic [31:0] nop_i;
        int wr_ops[$] = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 14};
        int s1_ops[$] = '{0, 1, 2, 3, 4, 5, 6, 7, 10, 11, 12, 14, 15};
        writer_m = '0; src1_m = '0; src2r_m = '0;
        foreach (wr_ops[k]) writer_m[wr_ops[k]] = 1'b1;
        foreach (s1_ops[k]) src1_m[s1_ops[k]] = 1'b1;
        for (int k = 0; k <= 12; k++) src2r_m[k] = 1'b1;
`ifdef FU_RA_FWD_EN
        writer_m[19] = 1'b1;
        src1_m[20]   = 1'b1;
`endif
        cnt_model = 0; scnt_model = 0;
        nop_i = enc(NOP, 1'b0, 4'd0, 4'd0, 4'd0);
        rst_n = 1'b0;
        of_in = nop_i; ex_in = nop_i; ma_in = nop_i; wb_in = nop_i;
        #3;
        check("reset_count", {16'd0, cnt}, 0);
        check("reset_count_small", {28'd0, s_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Forward to OF (source-1, then source-2)
        step(enc(0, 0, 1, 2, 3), nop_i, nop_i, enc(0, 0, 2, 4, 5));
        step(enc(0, 0, 1, 2, 3), nop_i, nop_i, enc(0, 0, 3, 4, 5));
        // EX priority: MA beats WB
        step(nop_i, enc(1, 0, 6, 7, 8), enc(0, 0, 7, 1, 1), enc(2, 0, 7, 1, 1));
        // Two idle cycles: counter should hold at 3
        step(nop_i, nop_i, nop_i, nop_i);
        step(nop_i, nop_i, nop_i, nop_i);
        check("count_after_3_fwd", {16'd0, cnt}, 3);
        step(nop_i, enc(1, 0, 6, 7, 8), enc(5, 0, 7, 1, 1), enc(2, 0, 7, 1, 1));
        check("ex_rs1_wb_when_ma_cmp", {30'd0, ex1}, 2);
        step(nop_i, enc(1, 0, 6, 7, 8), enc(5, 0, 7, 1, 1), nop_i);
        // Load-use: no forward from MA; WB forwards next cycle
        step(nop_i, enc(0, 0, 2, 9, 9), enc(14, 0, 9, 1, 0), nop_i);
        check("load_in_ma_rs1", {30'd0, ex1}, 0);
        step(nop_i, enc(0, 0, 2, 9, 9), nop_i, enc(14, 0, 9, 1, 0));
        check("load_in_wb_rs2", {30'd0, ex2}, 2);
        // Immediate suppresses source-2; store data uses rd field
        step(nop_i, enc(0, 1, 1, 2, 5), enc(0, 0, 5, 0, 0), nop_i);
        step(nop_i, enc(15, 0, 5, 2, 0), enc(0, 0, 5, 0, 0), nop_i);
        check("store_data_from_ma", {30'd0, ex2}, 1);
        step(nop_i, nop_i, enc(15, 0, 3, 2, 0), enc(14, 0, 3, 1, 0));
        check("wb_ma_store", {31'd0, wb_ma2}, 1);
        // Non-writers in WB with every operand matching r2
        step(enc(0, 0, 2, 2, 2), enc(0, 0, 2, 2, 2), nop_i, enc(5, 0, 2, 2, 2));
        step(enc(0, 0, 2, 2, 2), enc(0, 0, 2, 2, 2), enc(15, 0, 2, 2, 2), enc(15, 0, 2, 2, 2));
        step(enc(0, 0, 2, 2, 2), enc(0, 0, 2, 2, 2), nop_i, enc(16, 0, 2, 2, 2));
        step(enc(0, 0, 2, 2, 2), enc(0, 0, 2, 2, 2), nop_i, enc(NOP, 0, 2, 2, 2));
        // r0 forwards like any register
        step(enc(0, 0, 1, 0, 0), enc(0, 0, 1, 0, 0), enc(0, 0, 0, 0, 0), enc(0, 0, 0, 0, 0));
        // call/ret pairing through r15
        step(enc(20, 0, 0, 0, 0), enc(20, 0, 0, 0, 0), enc(19, 0, 0, 0, 0), enc(19, 0, 0, 0, 0));

        // Random mixes with a mid-run reset
        for (int n = 0; n < 300; n++) begin
            if (n == 150) pulse_reset();
            step(rnd_instr(), rnd_instr(), rnd_instr(), rnd_instr());
        end

        // Saturation of the narrow counter
        for (int n = 0; n < 20; n++) begin
            step(enc(0, 0, 1, 1, 1), nop_i, nop_i, enc(0, 0, 1, 0, 0));
        end
        check("small_count_saturated", {28'd0, s_cnt}, 15);
        pulse_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
- Combinational data-forwarding control for the 5-stage in-order TinyRISC pipeline (IF, OF, EX, MA, WB).
- Compares the instructions currently in OF, EX, MA and WB and produces the mux selects that route later-stage results back to earlier-stage operand inputs.
- Also keeps a small clocked statistic of forwarding activity.
- Sits beside the pipeline registers; the hazard/stall unit handles load-use stalls separately.

Parameters:
- CNT_W, 16, width of the forwarding-event counter.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- instruction_OF  input  32  instruction in OF stage
- instruction_EX  input  32  instruction in EX stage
- instruction_MA  input  32  instruction in MA stage
- instruction_WB  input  32  instruction in WB stage
- WB_OF_rs1  output  1  1 = OF source-1 takes the WB result
- WB_OF_rs2  output  1  1 = OF source-2 takes the WB result
- WB_MA_rs2  output  1  1 = MA store-data takes the WB result
- MAWB_EX_rs1  output  2  EX operand-1 select: 00 none, 01 MA, 10 WB
- MAWB_EX_rs2  output  2  EX operand-2 select: 00 none, 01 MA, 10 WB
- fwd_count  output  CNT_W  saturating count of cycles with any forwarding

Behaviour:
- Instruction fields:
  - opcode [31:27]
  - I bit [26]
  - rd [25:22]
  - rs1 [21:18]
  - rs2 [17:14]
- Opcodes:
  - add 00000, sub 00001, mul 00010, div 00011, mod 00100, cmp 00101
  - and 00110, or 00111, not 01000, mov 01001
  - lsl 01010, lsr 01011, asr 01100, nop 01101
  - ld 01110, st 01111
  - beq 10000, bgt 10001, b 10010, call 10011, ret 10100
  - Undefined opcodes are treated like nop.
- Writer (has destination rd): add, sub, mul, div, mod, and, or, not, mov, lsl, lsr, asr, ld. cmp, st, branches and nop do not write.
- Source-1 = rs1 field. It is read by add..cmp, and, or, lsl, lsr, asr, ld, st.
- Source-2:
  - st: the source-2 register is the rd field (store data), always read.
  - add..cmp, and, or, not, mov, lsl, lsr, asr: source-2 = rs2 field, read only when I=0.
  - All other instructions: no source-2.
- All outputs except fwd_count are purely combinational; zero latency; rst_n does not affect them.
- WB_OF_rs1 = WB is a writer AND OF reads source-1 AND WB.rd == OF source-1. WB_OF_rs2 is the same rule for source-2.
- WB_MA_rs2 = MA is st AND WB is a writer AND WB.rd == MA.rd.
- MAWB_EX_rsX (X = 1 or 2) requires EX to read source-X; otherwise the value is 00. When EX reads source-X:
  - 01 if MA is a writer, MA is not ld, and MA.rd == EX source-X.
  - else 10 if WB is a writer and WB.rd == EX source-X.
  - else 00.
  - MA always wins over WB. Value 11 is never produced.
- A load in MA is never forwarded to EX; the stall unit handles it. The WB stage still forwards the load on the following cycle.
- r0 is an ordinary register and is forwarded like any other.
- nop, or an all-zero-opcode bubble that the pipeline marks as nop, produces no forwarding.
- fwd_count:
  - Async reset to 0.
  - On each rising clk edge it increments when any of the five select outputs is non-zero.
  - Saturates at all-ones and does not wrap.

Optional Feature:
- Macro FU_RA_FWD_EN.
- When defined:
  - call is a writer with destination r15.
  - ret reads source-1 = r15.
  - Both take part in every rule above.
- When undefined: call and ret are neither writers nor readers.

Decomposition:
- Shared package tinyrisc_pkg holds:
  - opcode localparams
  - field bit-position constants
  - the select encodings FWD_NONE=2'b00, FWD_MA=2'b01, FWD_WB=2'b10
- One natural sub-module, fu_decode, instantiated once per stage. It takes a 32-bit instruction and returns is_writer, dest[3:0], reads_s1, s1[3:0], reads_s2, s2[3:0].

Test Plan:
- Forward to OF: OF=add r1,r2,r3 (I=0); WB=add r2,r4,r5 -> WB_OF_rs1=1, WB_OF_rs2=0. Then WB rd=r3 -> WB_OF_rs2=1.
- EX priority: EX=sub r6,r7,r8; MA=add r7,..; WB=mul r7,.. -> MAWB_EX_rs1=01. Change MA to cmp -> 10. Clear WB -> 00.
- Load-use: MA=ld r9,0[r1]; EX=add r2,r9,r9 -> MAWB_EX_rs1=00, MAWB_EX_rs2=00. Then WB=ld r9 with MA=nop -> both 10.
- Immediate and store: EX=add r1,r2,#5 (I=1) with MA rd=r5 -> MAWB_EX_rs2=00. EX=st r5,4[r2] with MA rd=r5 -> MAWB_EX_rs2=01. MA=st r3 with WB=ld r3 -> WB_MA_rs2=1.
- Non-writers: WB=cmp r2,r3 or st or beq or nop, every operand matching -> all outputs 0.
- Counter: rst_n low -> fwd_count=0. Then 3 cycles with forwarding and 2 without -> 3. Force 0xFFFF and keep forwarding -> stays 0xFFFF. Pulse rst_n mid-run -> 0 immediately.
